// File: rtl/rr_event_count_arbiter.sv
// rr_event_count_arbiter
//
// Round-robin arbiter that shares one modulo-MODULUS event counter among
// NREQ requesters. The granted requester's event strobes advance the counter.
// When the counter wraps, that requester gets a one-cycle done pulse, the
// counter is released and priority moves to the next requester. If the
// requester drops its request before the wrap, it gets a one-cycle abort pulse
// instead.
//
// Optional feature: define ARB_TIMEOUT_EN to enable an idle timeout. The grant
// is aborted after TIMEOUT consecutive granted cycles without a counted event.
//
// Ports:
//   clk    - clock, all state updates on posedge
//   reset  - asynchronous, active-high reset
//   req    - per-requester request level, held until done or abort
//   w      - per-requester event strobe, only the granted bit is counted
//   grant  - one-hot grant, zero when not counting
//   busy   - high while counting or signalling done
//   done   - one-cycle pulse to the requester whose count wrapped
//   abort  - one-cycle pulse to a requester whose grant ended without a wrap
//   count  - shared counter value, 0..MODULUS-1
//   ptr    - round-robin pointer (highest-priority requester index)
module rr_event_count_arbiter #(
    parameter int NREQ    = 4,
    parameter int MODULUS = 5,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] w,
    output logic [NREQ-1:0] grant,
    output logic            busy,
    output logic [NREQ-1:0] done,
    output logic [NREQ-1:0] abort,
    output logic [7:0]      count,
    output logic [2:0]      ptr
);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      gidx_q, gidx_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [7:0]      count_q, count_d;
    logic [NREQ-1:0] abort_q, abort_d;

    logic [NREQ-1:0]   g_onehot;
    logic [2:0]        gnext;
    logic              w_g;
    logic              req_g;
    logic              wrap;
    logic              tmo_hit;
    logic              sel_found;
    logic [2:0]        sel_idx;
    logic [2*NREQ-1:0] req_rot;

    assign g_onehot = {{(NREQ-1){1'b0}}, 1'b1} << gidx_q;
    assign gnext    = (gidx_q == 3'(NREQ-1)) ? 3'd0 : gidx_q + 3'd1;
    assign w_g      = |(w & g_onehot);
    assign req_g    = |(req & g_onehot);
    assign wrap     = w_g && (count_q == 8'(MODULUS-1));

    // Rotate the request vector so that bit 0 is the requester at ptr; the
    // first set bit then gives the round-robin winner without variable indexing.
    assign req_rot = {req, req} >> ptr_q;

    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!sel_found && req_rot[i]) begin
                sel_found = 1'b1;
                idx       = int'(ptr_q) + i;
                if (idx >= NREQ) idx = idx - NREQ;
                sel_idx   = 3'(idx);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;

    // Counts consecutive granted cycles without a counted event.
    always_comb begin
        tmo_d   = 16'd0;
        tmo_hit = 1'b0;
        if (state_q == S_COUNT && !w_g) begin
            tmo_d   = tmo_q + 16'd1;
            tmo_hit = (tmo_d == 16'(TIMEOUT));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tmo_q <= 16'd0;
        else       tmo_q <= tmo_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^16'(TIMEOUT);
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        abort_d = '0;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    gidx_d  = sel_idx;
                    count_d = 8'd0;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                // Wrap beats withdrawal, which beats timeout.
                if (wrap) begin
                    count_d = 8'd0;
                    state_d = S_DONE;
                end else if (!req_g || tmo_hit) begin
                    abort_d = g_onehot;
                    count_d = 8'd0;
                    ptr_d   = gnext;
                    state_d = S_IDLE;
                end else if (w_g) begin
                    count_d = count_q + 8'd1;
                end
            end
            S_DONE: begin
                ptr_d   = gnext;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            gidx_q  <= 3'd0;
            ptr_q   <= 3'd0;
            count_q <= 8'd0;
            abort_q <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            abort_q <= abort_d;
        end
    end

    assign grant = (state_q == S_COUNT) ? g_onehot : '0;
    assign done  = (state_q == S_DONE)  ? g_onehot : '0;
    assign busy  = (state_q != S_IDLE);
    assign abort = abort_q;
    assign count = count_q;
    assign ptr   = ptr_q;

endmodule

// File: tb/tb_rr_event_count_arbiter.sv
module tb_rr_event_count_arbiter;

    localparam int NREQ = 4;
    localparam int MOD  = 5;
    localparam int TMO  = 3;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] w = '0;
    logic [NREQ-1:0] grant, done, abort;
    logic            busy;
    logic [7:0]      count;
    logic [2:0]      ptr;

    rr_event_count_arbiter #(.NREQ(NREQ), .MODULUS(MOD), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .w(w), .grant(grant),
        .busy(busy), .done(done), .abort(abort), .count(count), .ptr(ptr)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] oh(input int k);
        return (k < 0) ? 32'd0 : (32'd1 << k);
    endfunction

    // Reference model: who owns the counter, how many events it has
    // accumulated, and which pulse (if any) is visible this cycle.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_ptr   = 0;
    int m_done  = -1;
    int m_abort = -1;
    int m_idle  = 0;

    always @(posedge clk) begin
        int nd, na, g;
        nd = -1;
        na = -1;
        if (reset) begin
            m_owner = -1; m_cnt = 0; m_ptr = 0; m_idle = 0;
        end else if (m_done >= 0) begin
            m_ptr = (m_done + 1) % NREQ;
        end else if (m_owner < 0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_owner < 0 && req[(m_ptr + i) % NREQ]) begin
                    m_owner = (m_ptr + i) % NREQ;
                    m_cnt   = 0;
                    m_idle  = 0;
                end
            end
        end else begin
            g = m_owner;
            if (w[g]) begin
                m_cnt++;
                m_idle = 0;
            end else begin
                m_idle++;
            end
            if (m_cnt == MOD) begin
                nd = g; m_owner = -1; m_cnt = 0;
            end else if (!req[g] || (TMO_ON && m_idle == TMO)) begin
                na = g; m_owner = -1; m_cnt = 0; m_ptr = (g + 1) % NREQ;
            end
        end
        m_done  = nd;
        m_abort = na;
        #1;
        chk("grant", 32'(grant), oh(m_owner));
        chk("done",  32'(done),  oh(m_done));
        chk("abort", 32'(abort), oh(m_abort));
        chk("busy",  32'(busy),  32'((m_owner >= 0) || (m_done >= 0)));
        chk("count", 32'(count), 32'(m_cnt));
        chk("ptr",   32'(ptr),   32'(m_ptr));
    end

    initial begin
        int first_ab, ab_n, gr_n;
        logic [3:0] exp_g;

        // Reset state
        repeat (3) @(negedge clk);
        chk("lit_rst_grant", 32'(grant), 32'd0);
        chk("lit_rst_ptr",   32'(ptr),   32'd0);
        chk("lit_rst_busy",  32'(busy),  32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single requester, w held high
        req = 4'b0001; w = 4'b0001;
        @(negedge clk);
        chk("lit_single_grant", 32'(grant), 32'h1);
        chk("lit_single_cnt0",  32'(count), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("lit_single_step", 32'(count), 32'(k));
        end
        @(negedge clk);
        chk("lit_single_done",  32'(done),  32'h1);
        chk("lit_single_gnull", 32'(grant), 32'h0);
        chk("lit_single_wrap",  32'(count), 32'd0);
        req = 4'b0000; w = 4'b0000;
        @(negedge clk);
        chk("lit_single_ptr",  32'(ptr),  32'd1);
        chk("lit_single_idle", 32'(busy), 32'd0);
        chk("lit_single_dn0",  32'(done), 32'h0);

        // Reset back to ptr 0, then fairness with everyone requesting
        reset = 1'b1;
        @(negedge clk);
        chk("lit_rst2_ptr", 32'(ptr), 32'd0);
        reset = 1'b0;
        req = 4'b1111; w = 4'b1111;
        for (int c = 0; c < 35; c++) begin
            @(negedge clk);
            exp_g = (c % 7 < 5) ? 4'(1 << ((c / 7) % 4)) : 4'b0000;
            chk("lit_fair_grant", 32'(grant), 32'(exp_g));
            if (c == 34) begin
                req = 4'b0000; w = 4'b0000;
            end
        end
        @(negedge clk);
        chk("lit_fair_ptr", 32'(ptr), 32'd1);

        // Ignored events, then withdrawal
        req = 4'b0010;
        @(negedge clk);
        chk("lit_wd_grant", 32'(grant), 32'h2);
        w = 4'b0010;
        repeat (2) @(negedge clk);
        chk("lit_wd_cnt2", 32'(count), 32'd2);
        w = 4'b1001;
        repeat (2) @(negedge clk);
        chk("lit_wd_ignored", 32'(count), 32'd2);
        chk("lit_wd_held",    32'(grant), 32'h2);
        req = 4'b0000; w = 4'b0000;
        @(negedge clk);
        chk("lit_wd_abort", 32'(abort), 32'h2);
        chk("lit_wd_nodn",  32'(done),  32'h0);
        chk("lit_wd_ptr",   32'(ptr),   32'd2);
        chk("lit_wd_cnt0",  32'(count), 32'd0);
        @(negedge clk);
        chk("lit_wd_ab1cy", 32'(abort), 32'h0);

        // Wrap and withdrawal in the same cycle
        req = 4'b0100;
        @(negedge clk);
        chk("lit_sim_grant", 32'(grant), 32'h4);
        w = 4'b0100;
        repeat (4) @(negedge clk);
        chk("lit_sim_cnt4", 32'(count), 32'd4);
        req = 4'b0000;
        @(negedge clk);
        chk("lit_sim_done",  32'(done),  32'h4);
        chk("lit_sim_noab",  32'(abort), 32'h0);
        w = 4'b0000;
        @(negedge clk);
        chk("lit_sim_noab2", 32'(abort), 32'h0);
        chk("lit_sim_ptr",   32'(ptr),   32'd3);

        // Reset in the middle of a count; search from ptr 3 wraps to 0
        req = 4'b0001;
        @(negedge clk);
        chk("lit_rmc_grant", 32'(grant), 32'h1);
        w = 4'b0001;
        repeat (2) @(negedge clk);
        chk("lit_rmc_cnt2", 32'(count), 32'd2);
        w = 4'b0000;
        reset = 1'b1;
        #1;
        chk("lit_rmc_cnt",   32'(count), 32'd0);
        chk("lit_rmc_grant0", 32'(grant), 32'h0);
        chk("lit_rmc_ptr",   32'(ptr),   32'd0);
        chk("lit_rmc_pulse", 32'({done, abort}), 32'h0);
        repeat (2) @(negedge clk);
        chk("lit_rmc_pulse2", 32'({done, abort}), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("lit_rmc_regrant", 32'(grant), 32'h1);

        // One event, then idle for a long time
        w = 4'b0001;
        @(negedge clk);
        chk("lit_tmo_cnt1", 32'(count), 32'd1);
        w = 4'b0000;
        first_ab = -1; ab_n = 0; gr_n = 0;
        for (int c = 1; c <= 110; c++) begin
            @(negedge clk);
            if (abort == 4'b0001) begin
                ab_n++;
                if (first_ab < 0) first_ab = c;
            end
            if (grant == 4'b0001) gr_n++;
        end
`ifdef ARB_TIMEOUT_EN
        chk("lit_tmo_first_abort", 32'(first_ab), 32'd3);
`else
        chk("lit_tmo_grant_held", 32'(gr_n), 32'd110);
        chk("lit_tmo_no_abort",   32'(ab_n), 32'd0);
`endif
        req = 4'b0000;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
